// File: rtl/delay_slot_scheduler_if.sv
// Request/grant bundle between the stimulus sequencers and the shared delay timer.
// The sequencer side is the master, the scheduler is the slave.
interface delay_slot_scheduler_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] delay;
    logic [NREQ*2-1:0]  scale;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [DW-1:0]      remaining;

    modport master (
        output req, delay, scale,
        input  gnt, done, busy, remaining
    );

    modport slave (
        input  req, delay, scale,
        output gnt, done, busy, remaining
    );
endinterface

// File: rtl/delay_slot_scheduler.sv
// Round-robin owner of one prescaled down-counter: grants a requester, waits
// delay*factor clocks, then pulses done back to it.
module delay_slot_scheduler #(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input logic                   clock,
    input logic                   reset_n,
    delay_slot_scheduler_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   winner, winner_nxt;
    logic [IW-1:0]   arb_idx, cand;
    logic            arb_hit;
    logic [DW-1:0]   remaining, remaining_nxt;
    logic [9:0]      presc, presc_nxt;
    logic [1:0]      scl_lat;
    logic            load_scale;

    // Prescaler value on which one unit has elapsed.
    function automatic logic [9:0] last_count(input logic [1:0] s);
        case (s)
            2'd0:    return 10'd0;
            2'd1:    return 10'd9;
            2'd2:    return 10'd99;
            default: return 10'd999;
        endcase
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] w);
        if (int'(w) == NREQ - 1) return '0;
        return w + IW'(1);
    endfunction

    // First set request at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (!arb_hit && bus.req[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        winner_nxt    = winner;
        remaining_nxt = remaining;
        presc_nxt     = presc;
        load_scale    = 1'b0;
        case (state)
            IDLE: begin
                if (arb_hit) begin
                    winner_nxt    = arb_idx;
                    load_scale    = 1'b1;
                    presc_nxt     = '0;
                    remaining_nxt = bus.delay[int'(arb_idx)*DW +: DW];
                    state_nxt     = (bus.delay[int'(arb_idx)*DW +: DW] == '0) ? DONE : COUNT;
                end
            end
            COUNT: begin
                // A dropped request beats a final tick in the same cycle.
                if (!bus.req[winner]) begin
                    state_nxt     = IDLE;
                    remaining_nxt = '0;
                    presc_nxt     = '0;
                    ptr_nxt       = next_ptr(winner);
                end else if (presc == last_count(scl_lat)) begin
                    presc_nxt     = '0;
                    remaining_nxt = remaining - DW'(1);
                    if (remaining == DW'(1)) state_nxt = DONE;
                end else begin
                    presc_nxt = presc + 10'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                ptr_nxt   = next_ptr(winner);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            winner    <= '0;
            remaining <= '0;
            presc     <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            winner    <= winner_nxt;
            remaining <= remaining_nxt;
            presc     <= presc_nxt;
        end
    end

    // Unit select is pure data; it is only consulted while COUNT is active.
    always_ff @(posedge clock) begin
        if (load_scale) scl_lat <= bus.scale[int'(arb_idx)*2 +: 2];
    end

    always_comb begin
        bus.gnt  = '0;
        bus.done = '0;
        if (state == COUNT) bus.gnt[winner]  = 1'b1;
        if (state == DONE)  bus.done[winner] = 1'b1;
    end

    assign bus.busy      = (state != IDLE);
    assign bus.remaining = remaining;
endmodule

// File: doc/delay_slot_scheduler.md
Name: delay_slot_scheduler

Overview:
- Shares one programmable delay timer among NREQ requesters; the timer models a timescale-style wait with a per-request unit multiplier.
- Each requester asks for a wait of `delay` units at a selected scale (x1, x10, x100 or x1000 clocks).
- The scheduler arbitrates round-robin, runs the shared prescaler and down-counter, and pulses `done` back to the winner.
- Sits between simulation-style stimulus sequencers and the shared time-base resource in the diag designs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, width of each delay field and of the down-counter.

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request level; held high until `done` or an abort.
- delay  input  NREQ*DW  packed delay counts; requester i occupies bits [i*DW +: DW].
- scale  input  NREQ*2  packed unit select; 0=x1, 1=x10, 2=x100, 3=x1000 clocks per unit.
- gnt  output  NREQ  one-hot grant, high while the winner's wait is in progress.
- done  output  NREQ  one-cycle completion pulse to the winner.
- busy  output  1  high in any state other than IDLE.
- remaining  output  DW  units left on the current wait.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State=IDLE; gnt=0, done=0, busy=0, remaining=0.
  - Prescaler=0; round-robin pointer=0, so requester 0 has highest priority.
- FSM states: IDLE, COUNT, DONE.
- IDLE, arbitration:
  - Arbitration runs only in IDLE and only if any req bit is high.
  - Search starts at the pointer and wraps modulo NREQ; the first set req wins. The winner index is registered.
  - The winner's delay and scale are latched; later changes to its inputs are ignored until the next grant.
- IDLE, transition:
  - delay != 0: next state COUNT, gnt[winner]=1, remaining=delay, prescaler=0.
  - delay == 0: next state DONE, gnt stays 0.
- COUNT:
  - Every cycle prescaler increments.
  - Tick: prescaler == factor-1, with factor = 1/10/100/1000. On a tick, prescaler returns to 0 and remaining decrements.
  - A tick with remaining==1 moves to DONE, with remaining=0.
  - The prescaler is 10 bits wide and never exceeds 999.
- DONE:
  - done[winner]=1 for exactly this one cycle; gnt=0.
  - Pointer becomes (winner+1) mod NREQ; next state IDLE.
- Latency, with req sampled high in IDLE at edge t0:
  - gnt is high from t0+1.
  - done is high in the cycle starting at t0+1+delay*factor.
  - delay=0: done at t0+1, gnt never asserted.
- Back-to-back: after DONE the scheduler spends at least one IDLE cycle before the next grant, so minimum spacing between grants is 2 cycles.
- Abort: the winner's req falls while in COUNT.
  - Next state IDLE, no done pulse, gnt=0, remaining=0.
  - Pointer advances past the aborted winner.
- Simultaneous events:
  - Abort and final tick in the same cycle: abort wins, no done.
  - Requests from non-winners during COUNT/DONE are ignored, not queued. They are re-evaluated in IDLE.
- Requester protocol: `req` must stay high until `done`. A requester that keeps req high after done is rearbitrated normally, with its priority now lowest.
- Mid-operation reset: reset_n low at any point clears everything asynchronously. No done is issued for the interrupted wait.
- Width rules:
  - delay is unsigned DW-bit; the maximum is 2^DW-1 units.
  - No overflow is possible: the counter only decrements from the loaded value.

Test Plan:
- Single request, delay=3 units at x1: req[0]=1, delay=3, scale=0 -> gnt[0] from t0+1; remaining 3,2,1; done[0] pulse at t0+4; then IDLE, busy=0.
- Scale timing, delay=2 units at x10: req[1], delay=2, scale=1 -> remaining steps 2->1 at t0+11 and 1->0 at t0+21; done[1] at t0+21; gnt[1] high for exactly 20 cycles.
- Round-robin, all four requesters, delay=1 units at x1: all req=1 after reset -> grant order 0,1,2,3,0 with each done 1 cycle after its grant. Requester 0 regains grant only after 3.
- Zero delay: req[2]=1, delay=0 -> done[2] at t0+1 with no gnt; pointer moves to 3.
- Abort, delay=5 units at x100: req[3]=1; drop req[3] at cycle 150 -> gnt=0 next cycle, no done, remaining=0. The next pending request from requester 0 is granted.
- Reset mid-count: reset_n=0 during COUNT with remaining=4 -> outputs immediately 0, state IDLE, pointer 0. No done after release; fresh arbitration starts at requester 0.
